// File: rtl/packer_pkg.sv
// Shared constants and helpers for the multi-channel byte-to-word packer.
package packer_pkg;

  localparam int BYTE_W    = 8;
  localparam int WORD_MAX  = 256;
  localparam int ENTRY_MAX = 320;

  function automatic int clog2_min1(input int n);
    int r;
    if (n <= 1) begin
      r = 1;
    end else begin
      r = $clog2(n);
    end
    return r;
  endfunction

  // FIFO entry layout is {ch, bytes, word}; callers truncate to their exact width.
  function automatic logic [ENTRY_MAX-1:0] pack_entry(
    input logic [31:0]         ch,
    input logic [31:0]         nbytes,
    input logic [WORD_MAX-1:0] word,
    input int                  cb_w,
    input int                  word_w
  );
    logic [ENTRY_MAX-1:0] e;
    e = ENTRY_MAX'(word)
      | (ENTRY_MAX'(nbytes) << word_w)
      | (ENTRY_MAX'(ch) << (word_w + cb_w));
    return e;
  endfunction

endpackage

// File: rtl/packer_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit for full/empty.
module packer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Storage and pointer update.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/chan_word_packer.sv
// Per-channel byte-to-word packer feeding one shared tagged FIFO.
// Optional PACKER_DROP_CNT_EN adds a saturating drop_cnt output.
module chan_word_packer
  import packer_pkg::*;
#(
  parameter int  WORD_BYTES = 3,
  parameter int  NUM_CH     = 4,
  parameter int  DEPTH      = 4,
  localparam int CH_W       = clog2_min1(NUM_CH),
  localparam int CB_W       = $clog2(WORD_BYTES + 1),
  localparam int WORD_W     = BYTE_W * WORD_BYTES
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   channel,
  input  logic [7:0]        data_in,
  input  logic              flush,
  output logic              in_ready,
  input  logic              rd,
  output logic              out_valid,
  output logic [WORD_W-1:0] data_out,
  output logic [CH_W-1:0]   out_ch,
  output logic [CB_W-1:0]   out_bytes
`ifdef PACKER_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int ENTRY_W = CH_W + CB_W + WORD_W;

  logic [CB_W-1:0]    cnt_q  [NUM_CH];
  logic [WORD_W-1:0]  part_q [NUM_CH];

  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ENTRY_W-1:0] fifo_din;

  logic               ch_ok;
  logic [CH_W-1:0]    ch_idx;
  logic               byte_acc;
  logic               flush_acc;
  logic [CB_W-1:0]    cnt_d;
  logic [WORD_W-1:0]  part_d;
  logic [CB_W-1:0]    new_cnt;
  logic [WORD_W-1:0]  new_part;
  logic               push;

  assign in_ready = !fifo_full;
  assign ch_ok    = (int'(channel) < NUM_CH);

  // Next-state for the addressed channel: add byte first, then decide on a push.
  always_comb begin
    ch_idx    = '0;
    new_cnt   = '0;
    new_part  = '0;
    push      = 1'b0;
    cnt_d     = '0;
    part_d    = '0;
    byte_acc  = wr_en && in_ready && ch_ok;
    flush_acc = flush && in_ready && ch_ok;
    if (ch_ok) begin
      ch_idx = channel;
    end else begin
      ch_idx = '0;
    end
    new_cnt  = cnt_q[ch_idx];
    new_part = part_q[ch_idx];
    if (byte_acc) begin
      new_part[int'(cnt_q[ch_idx]) * BYTE_W +: BYTE_W] = data_in;
      new_cnt = cnt_q[ch_idx] + CB_W'(1);
    end else begin
      new_cnt = cnt_q[ch_idx];
    end
    if (byte_acc && (new_cnt == CB_W'(WORD_BYTES))) begin
      push = 1'b1;
    end else if (flush_acc && (new_cnt != '0)) begin
      push = 1'b1;
    end else begin
      push = 1'b0;
    end
    if (push) begin
      cnt_d  = '0;
      part_d = '0;
    end else begin
      cnt_d  = new_cnt;
      part_d = new_part;
    end
  end

  assign fifo_din = ENTRY_W'(pack_entry(32'(ch_idx), 32'(new_cnt),
                                        WORD_MAX'(new_part), CB_W, WORD_W));

  // Per-channel byte count and partial word storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]  <= '0;
        part_q[c] <= '0;
      end
    end else if (byte_acc || flush_acc) begin
      cnt_q[ch_idx]  <= cnt_d;
      part_q[ch_idx] <= part_d;
    end
  end

  packer_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (rd),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign data_out  = fifo_head[WORD_W-1:0];
  assign out_bytes = fifo_head[WORD_W +: CB_W];
  assign out_ch    = fifo_head[WORD_W+CB_W +: CH_W];

`ifdef PACKER_DROP_CNT_EN
  logic [15:0] drop_q;

  // Saturating count of byte strobes that were not accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_q <= 16'h0000;
    end else if (wr_en && !(in_ready && ch_ok) && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'h0001;
    end else begin
      drop_q <= drop_q;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_chan_word_packer.sv
// Scoreboard bench for chan_word_packer: stimulus pushes expected words,
// a negedge monitor compares every popped head word.
module tb_chan_word_packer;

  typedef struct packed {
    logic [23:0] w;
    logic [1:0]  ch;
    logic [1:0]  nb;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wr_en;
  logic [1:0]  channel;
  logic [7:0]  data_in;
  logic        flush;
  logic        in_ready;
  logic        rd;
  logic        out_valid;
  logic [23:0] data_out;
  logic [1:0]  out_ch;
  logic [1:0]  out_bytes;
`ifdef PACKER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  chan_word_packer dut (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en     (wr_en),
    .channel   (channel),
    .data_in   (data_in),
    .flush     (flush),
    .in_ready  (in_ready),
    .rd        (rd),
    .out_valid (out_valid),
    .data_out  (data_out),
    .out_ch    (out_ch),
    .out_bytes (out_bytes)
`ifdef PACKER_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: compare the head word whenever a pop is about to happen.
  always @(negedge clk) begin
    if (resetn && rd && out_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%0h expected=none", data_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("word_data",  32'(data_out),  32'(e.w));
        chk("word_ch",    32'(out_ch),    32'(e.ch));
        chk("word_bytes", 32'(out_bytes), 32'(e.nb));
      end
    end
  end

  task automatic expect_word(input logic [23:0] w, input logic [1:0] ch, input logic [1:0] nb);
    exp_t e;
    e.w = w; e.ch = ch; e.nb = nb;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [1:0] ch, input logic [7:0] b, input logic fl);
    wr_en   = 1'b1;
    channel = ch;
    data_in = b;
    flush   = fl;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_flush(input logic [1:0] ch);
    flush   = 1'b1;
    channel = ch;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic pop_all();
    rd = 1'b1;
    for (int n = 0; n < 16 && out_valid; n++) begin
      @(posedge clk);
      #1;
    end
    rd = 1'b0;
    chk("drain_empty", 32'(out_valid), 32'd0);
  endtask

  initial begin
    resetn  = 1'b0;
    wr_en   = 1'b0;
    channel = 2'd0;
    data_in = 8'h00;
    flush   = 1'b0;
    rd      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_data_out",  32'(data_out),  32'd0);
    chk("rst_out_ch",    32'(out_ch),    32'd0);
    chk("rst_out_bytes", 32'(out_bytes), 32'd0);
`ifdef PACKER_DROP_CNT_EN
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // 1: single word on ch0, one-cycle latency
    expect_word(24'h561234, 2'd0, 2'd3);
    send(2'd0, 8'h34, 1'b0);
    send(2'd0, 8'h12, 1'b0);
    chk("t1_no_valid_early", 32'(out_valid), 32'd0);
    send(2'd0, 8'h56, 1'b0);
    chk("t1_valid_after_3rd", 32'(out_valid), 32'd1);
    pop_all();

    // 2: interleaved channels
    expect_word(24'h345612, 2'd1, 2'd3);
    expect_word(24'hCCBBAA, 2'd2, 2'd3);
    send(2'd1, 8'h12, 1'b0);
    send(2'd2, 8'hAA, 1'b0);
    send(2'd1, 8'h56, 1'b0);
    send(2'd2, 8'hBB, 1'b0);
    send(2'd1, 8'h34, 1'b0);
    send(2'd2, 8'hCC, 1'b0);
    pop_all();

    // 3: flush partial, byte+flush together, flush on empty channel
    expect_word(24'h002211, 2'd3, 2'd2);
    expect_word(24'h005544, 2'd2, 2'd2);
    send(2'd3, 8'h11, 1'b0);
    send(2'd3, 8'h22, 1'b0);
    do_flush(2'd3);
    send(2'd2, 8'h44, 1'b0);
    send(2'd2, 8'h55, 1'b1);
    pop_all();
    do_flush(2'd0);
    chk("t3_empty_flush", 32'(out_valid), 32'd0);

    // 4: fill FIFO, back-pressure, dropped byte
    expect_word(24'h030201, 2'd0, 2'd3);
    expect_word(24'h060504, 2'd0, 2'd3);
    expect_word(24'h090807, 2'd0, 2'd3);
    expect_word(24'h0C0B0A, 2'd0, 2'd3);
    for (int i = 1; i <= 12; i++) begin
      send(2'd0, 8'(i), 1'b0);
    end
    chk("t4_full_in_ready", 32'(in_ready), 32'd0);
    send(2'd1, 8'hEE, 1'b0);
    chk("t4_still_full", 32'(in_ready), 32'd0);
`ifdef PACKER_DROP_CNT_EN
    chk("t4_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    rd = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
    chk("t4_ready_after_rd", 32'(in_ready), 32'd1);
    pop_all();
    do_flush(2'd1);
    chk("t4_dropped_not_stored", 32'(out_valid), 32'd0);

    // 5: push and pop on the same edge at occupancy 2
    expect_word(24'hA3A2A1, 2'd2, 2'd3);
    expect_word(24'hB3B2B1, 2'd2, 2'd3);
    expect_word(24'hC3C2C1, 2'd0, 2'd3);
    expect_word(24'hD3D2D1, 2'd0, 2'd3);
    expect_word(24'hE3E2E1, 2'd0, 2'd3);
    send(2'd2, 8'hA1, 1'b0); send(2'd2, 8'hA2, 1'b0); send(2'd2, 8'hA3, 1'b0);
    send(2'd2, 8'hB1, 1'b0); send(2'd2, 8'hB2, 1'b0); send(2'd2, 8'hB3, 1'b0);
    send(2'd0, 8'hC1, 1'b0); send(2'd0, 8'hC2, 1'b0);
    rd = 1'b1;
    send(2'd0, 8'hC3, 1'b0);
    rd = 1'b0;
    send(2'd0, 8'hD1, 1'b0); send(2'd0, 8'hD2, 1'b0); send(2'd0, 8'hD3, 1'b0);
    chk("t5_occ3_ready", 32'(in_ready), 32'd1);
    send(2'd0, 8'hE1, 1'b0); send(2'd0, 8'hE2, 1'b0); send(2'd0, 8'hE3, 1'b0);
    chk("t5_occ4_full", 32'(in_ready), 32'd0);
    pop_all();

    // 6: reset mid-word discards partial
    send(2'd0, 8'h01, 1'b0);
    send(2'd0, 8'h02, 1'b0);
    #2;
    resetn = 1'b0;
    #2;
    chk("t6_rst_valid",    32'(out_valid), 32'd0);
    chk("t6_rst_ready",    32'(in_ready),  32'd1);
    chk("t6_rst_data_out", 32'(data_out),  32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    expect_word(24'h998877, 2'd0, 2'd3);
    send(2'd0, 8'h77, 1'b0);
    send(2'd0, 8'h88, 1'b0);
    send(2'd0, 8'h99, 1'b0);
    pop_all();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
